// File: rtl/rad_mcp_rx_pkg.sv
// Shared widths and sizing helper for the MCP receive drain.
package rad_mcp_rx_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int RX_COUNT_W    = 16;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rad_mcp_rx_fifo.sv
// Purpose: small circular buffer between the MCP receive side and the downstream stream.
// Latency: a pushed word is visible at head_dat one cycle after the push edge.
// Backpressure: full refuses push; pop on empty is ignored; no bypass between them.
module rad_mcp_rx_fifo
    import rad_mcp_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (occ_q == OCC_W'(DEPTH));
    assign empty    = (occ_q == '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: contents are only observed while occupancy is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rad_mcp_rx_drain.sv
// Purpose: drains MCP receive words into a valid/ready stream; counts loads, flags unstable data.
// Latency: out_valid rises one cycle after the bload that filled an empty buffer.
// Backpressure: bload is held off while the buffer is full; out_ready never reaches bload.
module rad_mcp_rx_drain
    import rad_mcp_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      bdata,
    input  logic                  bvalid,
    output logic                  bload,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RX_COUNT_W-1:0] rx_count,
    output logic                  err_unstable
);

    logic                  full;
    logic                  empty;
    logic                  pop;
    logic [RX_COUNT_W-1:0] rx_count_q, rx_count_d;
    logic                  err_unstable_q, err_unstable_d;
    logic                  prev_bvalid_q, prev_bvalid_d;
    logic                  prev_bload_q, prev_bload_d;
    logic [WIDTH-1:0]      prev_bdata_q, prev_bdata_d;

    assign bload        = bvalid & ~full & rst_n;
    assign out_valid    = ~empty & rst_n;
    assign pop          = out_valid & out_ready;
    assign rx_count     = rx_count_q;
    assign err_unstable = err_unstable_q;

    rad_mcp_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (bload),
        .push_dat (bdata),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head_dat (out_data)
    );

    // A word held without being loaded must not change; a held word right after a load is a new word.
    always_comb begin
        rx_count_d     = rx_count_q;
        err_unstable_d = err_unstable_q;
        prev_bvalid_d  = bvalid;
        prev_bload_d   = bload;
        prev_bdata_d   = bdata;
        if (bload) begin
            rx_count_d = rx_count_q + 1'b1;
        end
        if (prev_bvalid_q && !prev_bload_q && bvalid && (bdata != prev_bdata_q)) begin
            err_unstable_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_count_q     <= '0;
            err_unstable_q <= 1'b0;
            prev_bvalid_q  <= 1'b0;
            prev_bload_q   <= 1'b0;
            prev_bdata_q   <= '0;
        end else begin
            rx_count_q     <= rx_count_d;
            err_unstable_q <= err_unstable_d;
            prev_bvalid_q  <= prev_bvalid_d;
            prev_bload_q   <= prev_bload_d;
            prev_bdata_q   <= prev_bdata_d;
        end
    end

endmodule

// File: tb/tb_rad_mcp_rx_drain.sv
// Bench for rad_mcp_rx_drain: queue-based reference model plus directed scenarios with literal checks.
module tb_rad_mcp_rx_drain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] bdata;
    logic             bvalid;
    logic             bload;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      rx_count;
    logic             err_unstable;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [15:0]      m_cnt = '0;
    logic             m_err = 1'b0;
    logic             m_pv = 1'b0;
    logic             m_pl = 1'b0;
    logic [WIDTH-1:0] m_pd = '0;
    logic             m_ld, m_pp;
    logic             e_ld, e_ov;

    rad_mcp_rx_drain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bdata        (bdata),
        .bvalid       (bvalid),
        .bload        (bload),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rx_count     (rx_count),
        .err_unstable (err_unstable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: a bounded queue of words; load whenever valid and not full, pop whenever non-empty and ready.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt = '0;
            m_err = 1'b0;
            m_pv  = 1'b0;
            m_pl  = 1'b0;
            m_pd  = '0;
        end else begin
            m_ld = bvalid && (mq.size() < DEPTH);
            m_pp = (mq.size() > 0) && out_ready;
            if (m_pv && !m_pl && bvalid && (bdata != m_pd)) m_err = 1'b1;
            if (m_pp) void'(mq.pop_front());
            if (m_ld) begin
                mq.push_back(bdata);
                m_cnt = m_cnt + 16'd1;
            end
            m_pv = bvalid;
            m_pl = m_ld;
            m_pd = bdata;
        end
    end

    // Compare process: every cycle, mid-period, against the model.
    always @(negedge clk) begin
        e_ld = rst_n && bvalid && (mq.size() < DEPTH);
        e_ov = rst_n && (mq.size() > 0);
        chk("m_bload", 32'(bload), 32'(e_ld));
        chk("m_out_valid", 32'(out_valid), 32'(e_ov));
        if (e_ov) chk("m_out_data", 32'(out_data), 32'(mq[0]));
        if (rst_n) begin
            chk("m_rx_count", 32'(rx_count), 32'(m_cnt));
            chk("m_err_unstable", 32'(err_unstable), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
        bvalid    = v;
        bdata     = d;
        out_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 8'hEE, 1'b1);

        // Reset: no load, no valid even with bvalid high
        repeat (3) tick();
        @(negedge clk);
        chk("rst_bload", 32'(bload), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        tick();

        // Single word
        drive(1'b1, 8'hA5, 1'b1);
        @(negedge clk);
        chk("single_bload", 32'(bload), 32'd1);
        chk("single_no_bypass", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'hA5);
        chk("single_rx_count", 32'(rx_count), 32'd1);
        tick();

        // Backpressure: three words, only two fit
        drive(1'b1, 8'h01, 1'b0);
        tick();
        drive(1'b1, 8'h02, 1'b0);
        @(negedge clk);
        chk("bp_bload2", 32'(bload), 32'd1);
        tick();
        drive(1'b1, 8'h03, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("bp_bload3_held", 32'(bload), 32'd0);
            chk("bp_head_stable", 32'(out_data), 32'h01);
            tick();
        end
        // Full with simultaneous pop: no push this cycle, push next
        out_ready = 1'b1;
        @(negedge clk);
        chk("fullpop_bload0", 32'(bload), 32'd0);
        chk("fullpop_data01", 32'(out_data), 32'h01);
        tick();
        @(negedge clk);
        chk("fullpop_bload1", 32'(bload), 32'd1);
        chk("order_data02", 32'(out_data), 32'h02);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("order_data03", 32'(out_data), 32'h03);
        chk("bp_rx_count", 32'(rx_count), 32'd4);
        chk("bp_no_err", 32'(err_unstable), 32'd0);
        tick();

        // Instability: fill, then change held data without a load
        drive(1'b1, 8'h20, 1'b0);
        repeat (2) tick();
        drive(1'b1, 8'h10, 1'b0);
        tick();
        drive(1'b1, 8'h11, 1'b0);
        @(negedge clk);
        chk("unst_not_yet", 32'(err_unstable), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("unst_set", 32'(err_unstable), 32'd1);
        repeat (4) tick();
        @(negedge clk);
        chk("unst_sticky", 32'(err_unstable), 32'd1);
        tick();

        // Reset mid-operation with two words buffered
        drive(1'b1, 8'h33, 1'b0);
        tick();
        drive(1'b1, 8'h44, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid_in_rst", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_rx_count", 32'(rx_count), 32'd0);
        chk("midrst_err", 32'(err_unstable), 32'd0);
        tick();

        // Counter wrap: 65537 back-to-back loads with changing data
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            bvalid = 1'b1;
            bdata  = 8'(i);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("wrap_rx_count", 32'(rx_count), 32'h0001);
        chk("wrap_no_err", 32'(err_unstable), 32'd0);
        repeat (3) tick();

        // Normal operation after all that
        drive(1'b1, 8'h5A, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("post_out_data", 32'(out_data), 32'h5A);
        chk("post_rx_count", 32'(rx_count), 32'h0002);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
